// File: rtl/store_rmw_pkg.sv
// Shared encodings for the store path: size select (common with the load-side
// mux) and the read-modify-write FSM state codes.
package store_rmw_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A request is rejected for the illegal size code or a size/offset mismatch.
  function automatic logic store_rejected(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_ILL) ||
           ((size == SZ_WORD) && (lane != 2'b00)) ||
           ((size == SZ_HALF) && lane[0]);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: overlays the store data onto the old memory word
// using little-endian byte lanes.
module store_lane_merge
  import store_rmw_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Replace only the lanes addressed by the store; word stores pass through.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_WORD: merged = wdata;
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_rmw.sv
// Sub-word store engine: word stores write directly, byte/half stores read the
// containing word, wait READ_WAIT cycles, merge and write back.
module store_rmw
  import store_rmw_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  StoreSize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  logic [2:0]  state;
  logic [2:0]  wait_cnt;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] hold_q;
  logic        err_q;

  // Request capture and state sequencing; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      size_q   <= '0;
      lane_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= '0;
      err_q    <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            size_q   <= StoreSize;
            lane_q   <= addr[1:0];
            wdata_q  <= wdata;
            mem_addr <= {addr[31:2], 2'b00};
            err_q    <= 1'b0;
            if (store_rejected(StoreSize, addr[1:0])) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else if (StoreSize == SZ_WORD) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          wait_cnt <= 3'(READ_WAIT - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            hold_q <= mem_rdata;
            state  <= ST_WRITE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_WRITE: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Merged word is formed from registered state only, so it is zero out of reset.
  store_lane_merge u_merge (
    .old_word (hold_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .lane     (lane_q),
    .merged   (mem_wdata)
  );

  assign mem_wr = (state == ST_WRITE);
  assign done   = (state == ST_DONE);
  assign err    = (state == ST_DONE) && err_q;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_store_rmw.sv
// Bench for store_rmw: two instances (READ_WAIT=1 and 3) against a word-array
// memory whose read data only becomes valid READ_WAIT cycles after the address.
module tb_store_rmw;

  localparam logic [1:0] W = 2'b00, B = 2'b01, H = 2'b10, I = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [2];
  logic        start_s [2];
  logic [1:0]  size_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] maddr_s [2];
  logic        mwr_s   [2];
  logic [31:0] mwdata_s[2];
  logic [31:0] rdata_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  int          age  [2];

  int n_assert = 0;
  int n_fail   = 0;

  store_rmw #(.READ_WAIT(1)) u0 (
    .clk(clk), .reset(rst_n[0]), .start(start_s[0]), .StoreSize(size_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .mem_addr(maddr_s[0]), .mem_wr(mwr_s[0]),
    .mem_wdata(mwdata_s[0]), .mem_rdata(rdata_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .err(err_s[0]));

  store_rmw #(.READ_WAIT(3)) u1 (
    .clk(clk), .reset(rst_n[1]), .start(start_s[1]), .StoreSize(size_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .mem_addr(maddr_s[1]), .mem_wr(mwr_s[1]),
    .mem_wdata(mwdata_s[1]), .mem_rdata(rdata_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .err(err_s[1]));

  // Cycles spent busy; read data is garbage until the memory latency has elapsed.
  always @(posedge clk) begin
    age[0] <= busy_s[0] ? age[0] + 1 : 0;
    age[1] <= busy_s[1] ? age[1] + 1 : 0;
  end

  always_comb begin
    rdata_s[0] = (age[0] >= 1) ? mem0[maddr_s[0][11:2]] : 32'hBADBAD00;
    rdata_s[1] = (age[1] >= 3) ? mem1[maddr_s[1][11:2]] : 32'hBADBAD01;
  end

  function automatic int rw(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic mem_put(input int d, input logic [31:0] a, input logic [31:0] v);
    if (d == 0) mem0[a[11:2]] = v;
    else        mem1[a[11:2]] = v;
  endtask

  function automatic logic [31:0] mem_get(input int d, input logic [31:0] a);
    return (d == 0) ? mem0[a[11:2]] : mem1[a[11:2]];
  endfunction

  // Reference rules computed with plain arithmetic on byte offsets.
  function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == I) || (sz == W && (a % 4) != 0) || (sz == H && (a % 2) != 0);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [31:0] a, input logic [31:0] wd);
    int sh;
    if (sz == W) return wd;
    if (sz == B) begin
      sh = (a % 4) * 8;
      return (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    sh = ((a / 2) % 2) * 16;
    return (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble(input int d);
    addr_s[d]  = $urandom;
    wdata_s[d] = $urandom;
    size_s[d]  = 2'($urandom);
  endtask

  // One store from IDLE; a stray start may be pulsed at cycle pulse_at.
  task automatic run_store(input int d, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] old, input int pulse_at,
                           input string tag);
    bit          bad;
    logic [31:0] exp_word, wa, wdv;
    int          lat, nwr, done_cyc;
    logic        got_err, stray;
    mem_put(d, a, old);
    bad      = ref_bad(sz, a);
    exp_word = ref_merge(old, sz, a, wd);
    lat      = bad ? 1 : (sz == W) ? 2 : 3 + rw(d);
    start_s[d] = 1'b1; size_s[d] = sz; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk);
    #1 start_s[d] = 1'b0;
    scramble(d);
    nwr = 0; done_cyc = 0; stray = 0; got_err = 0; wa = 0; wdv = 0;
    for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (mwr_s[d]) begin
        nwr++; wa = maddr_s[d]; wdv = mwdata_s[d];
        mem_put(d, maddr_s[d], mwdata_s[d]);
      end
      if (err_s[d] && !done_s[d]) stray = 1'b1;
      if (done_s[d]) begin done_cyc = k; got_err = err_s[d]; end
      if (k == pulse_at) begin
        start_s[d] = 1'b1; size_s[d] = W; addr_s[d] = a & ~32'h3;
      end else if (k == pulse_at + 1) begin
        start_s[d] = 1'b0;
      end
    end
    chk({tag, " latency"}, done_cyc, lat);
    chk({tag, " err"}, {31'd0, got_err}, {31'd0, bad});
    chk({tag, " err_outside_done"}, {31'd0, stray}, 32'd0);
    chk({tag, " write_count"}, nwr, bad ? 0 : 1);
    if (!bad) begin
      chk({tag, " write_addr"}, wa, a & ~32'h3);
      chk({tag, " write_data"}, wdv, exp_word);
    end
    chk({tag, " mem_word"}, mem_get(d, a), bad ? old : exp_word);
    @(negedge clk);
    chk({tag, " idle_after_done"}, {31'd0, busy_s[d]}, 32'd0);
    chk({tag, " no_write_after_done"}, {31'd0, mwr_s[d]}, 32'd0);
    start_s[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          seen;
    for (int i = 0; i < 1024; i++) begin mem0[i] = '0; mem1[i] = '0; end
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start_s[d] = 1'b0; size_s[d] = '0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset busy", {31'd0, busy_s[d]}, 32'd0);
      chk("reset mem_wr", {31'd0, mwr_s[d]}, 32'd0);
      chk("reset done", {31'd0, done_s[d]}, 32'd0);
      chk("reset err", {31'd0, err_s[d]}, 32'd0);
      chk("reset mem_addr", maddr_s[d], 32'd0);
      chk("reset mem_wdata", mwdata_s[d], 32'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_store(0, B, 32'h102, 32'h000000AB, 32'h11223344, -1, "byte_lane2");
    run_store(0, H, 32'h206, 32'h00001234, 32'hDEADBEEF, -1, "half_hi");
    run_store(0, H, 32'h204, 32'h00005678, 32'hDEADBEEF, -1, "half_lo");
    run_store(0, H, 32'h207, 32'h00001234, 32'hDEADBEEF, -1, "half_misaligned");
    run_store(0, W, 32'h300, 32'hCAFEF00D, 32'h01020304, -1, "word");
    run_store(0, W, 32'h302, 32'hCAFEF00D, 32'h01020304, -1, "word_misaligned");
    run_store(0, I, 32'h310, 32'h55555555, 32'h0A0B0C0D, -1, "illegal_size");
    run_store(1, B, 32'h400, 32'hFFFFFF5A, 32'h11223344, -1, "rw3_byte_lane0");
    run_store(1, B, 32'h401, 32'h000000C3, 32'h11223344, -1, "rw3_byte_lane1");
    run_store(1, B, 32'h403, 32'h00000099, 32'h11223344, 3, "rw3_byte_start_in_wait");
    run_store(0, W, 32'h500, 32'h12345678, 32'h0, 2, "word_start_in_done");
    run_store(1, H, 32'h602, 32'hABCD4321, 32'h76543210, 4, "rw3_half_start_in_wait");

    // Randomised sizes, offsets, data and stray starts.
    for (int i = 0; i < 60; i++) begin
      run_store(i % 2, 2'($urandom), $urandom, $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1, "random");
    end

    // Reset asserted while in WRITE aborts without a done pulse.
    a = 32'h701;
    mem_put(0, a, 32'h89ABCDEF);
    start_s[0] = 1'b1; size_s[0] = B; addr_s[0] = a; wdata_s[0] = 32'h77;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    seen = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      @(negedge clk);
      if (mwr_s[0]) begin
        seen = 1;
        mem_put(0, maddr_s[0], mwdata_s[0]);
        rst_n[0] = 1'b0;
      end
    end
    chk("rst_write reached", seen, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_write busy", {31'd0, busy_s[0]}, 32'd0);
      chk("rst_write mem_wr", {31'd0, mwr_s[0]}, 32'd0);
      chk("rst_write done", {31'd0, done_s[0]}, 32'd0);
    end
    chk("rst_write mem_addr", maddr_s[0], 32'd0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    run_store(0, H, 32'h802, 32'h0000BEEF, 32'h13579BDF, -1, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/store_rmw.md
STORE_RMW -- requirements
Module: store_rmw

Interface
REQ-001 Parameter: READ_WAIT, default 1; number of wait cycles between presenting the read address and mem_rdata being valid (range 1..7).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  reset is synchronous and active-low; asserted when reset=0, sampled on clk rising edge.
REQ-004 Port: start  in  1  store request strobe; accepted only in IDLE.
REQ-005 Port: StoreSize  in  2  00 = word, 01 = byte, 10 = halfword, 11 = illegal; same encoding as the load-side size select.
REQ-006 Port: addr  in  32  store byte address.
REQ-007 Port: wdata  in  32  register data to store; byte uses [7:0], half uses [15:0].
REQ-008 Port: mem_addr  out  32  word-aligned memory address, {addr[31:2],2'b00}.
REQ-009 Port: mem_wr  out  1  memory write enable.
REQ-010 Port: mem_wdata  out  32  full word written to memory.
REQ-011 Port: mem_rdata  in  32  memory read data.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: done  out  1  one-cycle completion pulse.
REQ-014 Port: err  out  1  valid with done; 1 = request rejected, no memory write.

Function
REQ-015 On start in IDLE, addr, wdata and StoreSize shall be registered; inputs are ignored afterwards until the next IDLE.
REQ-016 FSM states: IDLE, READ, WAIT, WRITE, DONE.
REQ-017 IDLE + start + word + addr[1:0]=00 -> WRITE; byte, or half with addr[0]=0 -> READ; illegal size or misalignment -> DONE with err=1.
REQ-018 Misalignment: word with addr[1:0]!=00, half with addr[0]=1.
REQ-019 READ lasts one cycle, drives mem_addr with mem_wr=0, loads the wait counter with READ_WAIT-1, then -> WAIT.
REQ-020 WAIT counts down to 0, then captures mem_rdata into a holding register and -> WRITE.
REQ-021 WRITE lasts one cycle with mem_wr=1, mem_addr held, mem_wdata = merged word; then -> DONE.
REQ-022 Merge, little-endian lanes: byte replaces bits [8*addr[1:0]+7 : 8*addr[1:0]] of the captured word with wdata[7:0]; half replaces [15:0] (addr[1]=0) or [31:16] (addr[1]=1) with wdata[15:0]; word writes wdata unchanged.
REQ-023 DONE lasts one cycle with done=1 and err valid; then -> IDLE. err shall be 0 in all other states.
REQ-024 Latency from start to done: word = 2 cycles; byte/half = 3+READ_WAIT cycles; error = 1 cycle.
REQ-025 mem_wr shall be 1 only in WRITE; never on an error path.
REQ-026 start while busy shall be ignored, with no queuing.
REQ-027 start in the same cycle as a DONE pulse shall be ignored; it is accepted only in IDLE.

Reset
REQ-028 reset=0 at an edge -> IDLE; mem_wr, done, err and busy = 0; mem_addr, mem_wdata and holding registers = 0.
REQ-029 Reset mid-operation, including in WRITE, shall abort with no further mem_wr and no done pulse.

Structure
REQ-030 The shared package holds the StoreSize encodings (shared with the load-side mux) and the FSM state encoding.
REQ-031 Lane merging is one combinational sub-module, store_lane_merge (inputs: old word, wdata, size, addr[1:0]; output: merged word).

Verification
REQ-032 Byte store: old word 0x11223344 at 0x100, addr=0x102, wdata=0xAB, READ_WAIT=1 -> single write of 0x11AB3344 to 0x100, done at cycle 4, err=0.
REQ-033 Half store: old word 0xDEADBEEF, addr=0x206, wdata=0x1234 -> write 0x1234BEEF to 0x204; misaligned addr=0x207 -> done at cycle 1, err=1, no mem_wr.
REQ-034 Word store: addr=0x300, wdata=0xCAFEF00D -> mem_wr in cycle 1 only, done at cycle 2, no read phase; StoreSize=11 -> err=1, no write.
REQ-035 READ_WAIT=3 byte store -> done at cycle 6; a second start asserted during WAIT is ignored, with exactly one write.
REQ-036 reset=0 during WRITE -> next cycle IDLE, mem_wr=0, no done; a new start after reset is accepted normally.
